// File: rtl/eprom_pgm_pkg.sv
// Shared encodings for the EPROM programming sequencer: operating modes,
// FSM state codes and the timing-counter width helper.
package eprom_pgm_pkg;

    typedef enum logic [1:0] {
        PGM_PROG        = 2'b00,
        PGM_VERIFY      = 2'b01,
        PGM_BLANK       = 2'b10,
        PGM_PROG_VERIFY = 2'b11
    } pgm_mode_e;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_SETUP = 4'd2;
    localparam logic [3:0] ST_PULSE = 4'd3;
    localparam logic [3:0] ST_HOLD  = 4'd4;
    localparam logic [3:0] ST_READ  = 4'd5;
    localparam logic [3:0] ST_CHECK = 4'd6;
    localparam logic [3:0] ST_NEXT  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    // An erased EPROM cell reads as all ones; replicated to DATA_W by the user.
    localparam logic BLANK_BIT = 1'b1;

    function automatic int dly_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pgm_delay.sv
// Loadable down-counter shared by all timed sequencer states; tc pulses for
// one cycle when a loaded count has run down to zero.
module pgm_delay #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;
    logic         run;

    assign tc = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (tc) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/eprom_pgm_seq.sv
// EPROM programming sequencer: program, verify, blank-check and program+verify
// over a byte stream with programmable setup/pulse/hold/read timing.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | accept next byte (blank check skips the handshake)
// SETUP | vdd_25 and data driven, address/data settling
// PULSE | prog_ce high
// HOLD  | prog_ce low, vdd_25 still high
// READ  | rd_n low, sample eprom_dq_in in the last cycle
// CHECK | compare sampled value with expected
// NEXT  | advance address, decrement remaining count
// DONE  | one-cycle done pulse
module eprom_pgm_seq
    import eprom_pgm_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 100,
    parameter int PULSE_CYC = 2500000,
    parameter int HOLD_CYC  = 100,
    parameter int READ_CYC  = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [ADDR_W-1:0] eprom_addr,
    output logic [DATA_W-1:0] eprom_dq_out,
    output logic              eprom_dq_oe,
    input  logic [DATA_W-1:0] eprom_dq_in,
    output logic              prog_ce,
    output logic              vdd_25,
    output logic              rd_n
);

    localparam int DLY_W = dly_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, READ_CYC);
    localparam logic [DATA_W-1:0] BLANK_VAL = {DATA_W{BLANK_BIT}};

    logic [3:0]        state, state_nx;
    pgm_mode_e         mode_q, mode_d;
    logic [ADDR_W:0]   remain;
    logic [DATA_W-1:0] expect_q, rd_q;
    logic              hs, abort_act, start_acc, is_pgm, mismatch;
    logic              dly_load, dly_tc;
    logic [DLY_W-1:0]  dly_val;

    assign hs        = wr_valid && wr_ready;
    assign abort_act = abort && (state != ST_IDLE);
    assign start_acc = start && !abort && (state == ST_IDLE);
    assign is_pgm    = (mode_q == PGM_PROG) || (mode_q == PGM_PROG_VERIFY);
    assign mismatch  = (rd_q != expect_q);
    assign mode_d    = start_acc ? pgm_mode_e'(mode) : mode_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_acc) state_nx = (count == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: begin
                if (mode_q == PGM_BLANK) state_nx = ST_READ;
                else if (hs)             state_nx = is_pgm ? ST_SETUP : ST_READ;
            end
            ST_SETUP: if (dly_tc) state_nx = ST_PULSE;
            ST_PULSE: if (dly_tc) state_nx = ST_HOLD;
            ST_HOLD:  if (dly_tc) state_nx = (mode_q == PGM_PROG) ? ST_NEXT : ST_READ;
            ST_READ:  if (dly_tc) state_nx = ST_CHECK;
            ST_CHECK: state_nx = mismatch ? ST_DONE : ST_NEXT;
            ST_NEXT:  state_nx = (remain == (ADDR_W+1)'(1)) ? ST_DONE : ST_FETCH;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort_act) state_nx = ST_IDLE;
    end

    // The delay is loaded on entry into each timed state so its length is exact.
    always_comb begin
        dly_val = '0;
        case (state_nx)
            ST_SETUP: dly_val = DLY_W'(SETUP_CYC - 1);
            ST_PULSE: dly_val = DLY_W'(PULSE_CYC - 1);
            ST_HOLD:  dly_val = DLY_W'(HOLD_CYC - 1);
            ST_READ:  dly_val = DLY_W'(READ_CYC - 1);
            default:  dly_val = '0;
        endcase
    end

    assign dly_load = (state_nx != state) &&
                      (state_nx inside {ST_SETUP, ST_PULSE, ST_HOLD, ST_READ});

    pgm_delay #(.W(DLY_W)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .tc       (dly_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mode_q       <= PGM_PROG;
            remain       <= '0;
            expect_q     <= '0;
            rd_q         <= '0;
            wr_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_addr     <= '0;
            err_data     <= '0;
            eprom_addr   <= '0;
            eprom_dq_out <= '0;
            eprom_dq_oe  <= 1'b0;
            prog_ce      <= 1'b0;
            vdd_25       <= 1'b0;
            rd_n         <= 1'b1;
        end else begin
            state       <= state_nx;
            mode_q      <= mode_d;
            // Strobes are decoded from the next state so they switch only on
            // state entry/exit and all drop together on abort.
            busy        <= (state_nx != ST_IDLE);
            done        <= (state_nx == ST_DONE);
            wr_ready    <= (state_nx == ST_FETCH) && (mode_d != PGM_BLANK);
            vdd_25      <= state_nx inside {ST_SETUP, ST_PULSE, ST_HOLD};
            eprom_dq_oe <= state_nx inside {ST_SETUP, ST_PULSE, ST_HOLD};
            prog_ce     <= (state_nx == ST_PULSE);
            rd_n        <= (state_nx != ST_READ);
            if (!abort_act) begin
                case (state)
                    ST_IDLE: if (start_acc) begin
                        eprom_addr <= base_addr;
                        remain     <= count;
                        err        <= 1'b0;
                    end
                    ST_FETCH: begin
                        if (mode_q == PGM_BLANK) begin
                            expect_q <= BLANK_VAL;
                        end else if (hs) begin
                            expect_q     <= wr_data;
                            eprom_dq_out <= wr_data;
                        end
                    end
                    ST_READ:  if (dly_tc) rd_q <= eprom_dq_in;
                    ST_CHECK: if (mismatch) begin
                        err      <= 1'b1;
                        err_addr <= eprom_addr;
                        err_data <= rd_q;
                    end
                    ST_NEXT: begin
                        eprom_addr <= eprom_addr + 1'b1;
                        remain     <= remain - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eprom_pgm_seq.sv
// Self-checking bench: directed scenarios plus random operations checked
// against an operation-level reference model and an EPROM memory model.
module tb_eprom_pgm_seq;
    import eprom_pgm_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int S  = 3;
    localparam int P  = 5;
    localparam int H  = 2;
    localparam int R  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready, busy, done, err;
    logic [AW-1:0] err_addr, eprom_addr;
    logic [DW-1:0] err_data, eprom_dq_out, eprom_dq_in;
    logic          eprom_dq_oe, prog_ce, vdd_25, rd_n;

    always #5 clk = ~clk;

    eprom_pgm_seq #(
        .ADDR_W(AW), .DATA_W(DW),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .READ_CYC(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .base_addr(base_addr), .count(count), .abort(abort),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .err_data(err_data), .eprom_addr(eprom_addr),
        .eprom_dq_out(eprom_dq_out), .eprom_dq_oe(eprom_dq_oe),
        .eprom_dq_in(eprom_dq_in), .prog_ce(prog_ce), .vdd_25(vdd_25),
        .rd_n(rd_n)
    );

    // EPROM model with an optional stuck location
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          stuck_en = 1'b0;
    logic [AW-1:0] stuck_addr = '0;
    logic [DW-1:0] stuck_val = '0;
    assign eprom_dq_in = (stuck_en && eprom_addr == stuck_addr) ? stuck_val : mem[eprom_addr];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observation state
    int            cyc = 0;
    int            pulse_len = 0, rd_len = 0, vdd_run = 0;
    int            done_hi = 0, done_cyc = 0;
    bit            prog_prev = 0, done_prev = 0, abort_seen = 0;
    logic [AW-1:0] pg_addr, rd_cap;
    logic [DW-1:0] pg_data;
    logic [AW-1:0] prog_aq[$];
    logic [DW-1:0] prog_dq[$];
    logic [AW-1:0] rd_aq[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] op_data[$];
    int            feed_stall = 0;
    bit            hs_pend = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (prog_ce) begin
            if (!prog_prev) begin
                chk("setup_before_pulse", int'(vdd_run >= S), 1);
                chk("oe_at_pulse", eprom_dq_oe, 1);
                pg_addr = eprom_addr;
                pg_data = eprom_dq_out;
            end
            pulse_len++;
        end else if (prog_prev) begin
            if (!abort_seen) begin
                chk("pulse_len", pulse_len, P);
                mem[pg_addr] = pg_data;
                prog_aq.push_back(pg_addr);
                prog_dq.push_back(pg_data);
            end
            pulse_len = 0;
        end
        prog_prev = prog_ce;
        vdd_run = vdd_25 ? vdd_run + 1 : 0;
        if (!rd_n) begin
            if (rd_len == 0) rd_cap = eprom_addr;
            rd_len++;
        end else if (rd_len > 0) begin
            if (!abort_seen) begin
                chk("rd_len", rd_len, R);
                rd_aq.push_back(rd_cap);
            end
            rd_len = 0;
        end
        if (done) begin
            if (!done_prev) done_cyc = cyc;
            done_hi++;
        end
        done_prev = done;
    end

    // byte producer: presents feed_q with optional random stalls
    initial forever begin
        @(negedge clk);
        if (hs_pend && feed_q.size() > 0) void'(feed_q.pop_front());
        if (feed_q.size() > 0 && $urandom_range(99) >= feed_stall) begin
            wr_valid = 1'b1;
            wr_data  = feed_q[0];
        end else begin
            wr_valid = 1'b0;
        end
        hs_pend = wr_valid && wr_ready;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_prog_ce"}, prog_ce, 0);
        chk({tag, "_vdd_25"}, vdd_25, 0);
        chk({tag, "_dq_oe"}, eprom_dq_oe, 0);
        chk({tag, "_rd_n"}, rd_n, 1);
        chk({tag, "_addr"}, eprom_addr, 0);
        chk({tag, "_dq_out"}, eprom_dq_out, 0);
        chk({tag, "_err_addr"}, err_addr, 0);
        chk({tag, "_err_data"}, err_data, 0);
    endtask

    task automatic run_op(input logic [1:0] m, input logic [AW-1:0] b, input int n,
                          input int stall_pct, input bit chk_lat, input int hold_n,
                          input int dup_at);
        logic [AW-1:0] e_pa[$];
        logic [DW-1:0] e_pd[$];
        logic [AW-1:0] e_ra[$];
        bit            e_err, pg, rd;
        logic [AW-1:0] e_ea, a;
        logic [DW-1:0] e_ed, rv, ev;
        int            e_lat, st_cyc, t;
        // reference model: per-location program/read outcome and cycle cost
        e_err = 0; e_lat = 0; e_ea = '0; e_ed = '0;
        pg = (m == PGM_PROG) || (m == PGM_PROG_VERIFY);
        rd = (m != PGM_PROG);
        for (int i = 0; i < n && !e_err; i++) begin
            a  = AW'(b + i);
            ev = (m == PGM_BLANK) ? 8'hFF : op_data[i];
            if (pg) begin
                e_pa.push_back(a);
                e_pd.push_back(op_data[i]);
            end
            if (rd) begin
                rv = (stuck_en && a == stuck_addr) ? stuck_val : (pg ? op_data[i] : mem[a]);
                e_ra.push_back(a);
                if (rv != ev) begin
                    e_err = 1; e_ea = a; e_ed = rv;
                end
            end
            e_lat += 1 + (pg ? S + P + H : 0) + (rd ? R + 1 : 0) + (e_err ? 0 : 1);
        end

        prog_aq.delete(); prog_dq.delete(); rd_aq.delete();
        done_hi = 0; abort_seen = 0;
        feed_stall = (hold_n > 0) ? 100 : stall_pct;
        feed_q.delete();
        if (m != PGM_BLANK)
            for (int i = 0; i < n; i++) feed_q.push_back(op_data[i]);
        @(negedge clk);
        mode = m; base_addr = b; count = (AW+1)'(n); start = 1'b1;
        st_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < hold_n; i++) begin
            chk("stall_strobes", {prog_ce, vdd_25, eprom_dq_oe, !rd_n}, 0);
            chk("stall_in_fetch", int'(wr_ready && busy), 1);
            @(negedge clk);
        end
        feed_stall = stall_pct;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
            if (dup_at != 0 && t == dup_at) begin
                start = 1'b1; mode = PGM_PROG; base_addr = 11'h400; count = 12'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("op_timeout", busy, 0);
        repeat (3) @(negedge clk);
        chk("idle_after", busy, 0);
        feed_q.delete();

        chk("n_prog", prog_aq.size(), e_pa.size());
        for (int i = 0; i < e_pa.size() && i < prog_aq.size(); i++) begin
            chk("prog_addr", prog_aq[i], e_pa[i]);
            chk("prog_data", prog_dq[i], e_pd[i]);
        end
        chk("n_read", rd_aq.size(), e_ra.size());
        for (int i = 0; i < e_ra.size() && i < rd_aq.size(); i++)
            chk("read_addr", rd_aq[i], e_ra[i]);
        chk("err", err, e_err);
        if (e_err) begin
            chk("err_addr", err_addr, e_ea);
            chk("err_data", err_data, e_ed);
        end
        chk("done_pulse", done_hi, 1);
        if (chk_lat) chk("latency", done_cyc - st_cyc, e_lat);
    endtask

    initial begin
        int t;
        logic [1:0]    rm;
        logic [AW-1:0] rb, ra;
        int            rn, rs;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // program with address wrap
        op_data = '{8'hA5, 8'h5A, 8'h3C};
        run_op(PGM_PROG, 11'h7FE, 3, 0, 1, 0, 0);

        // blank check hitting a programmed bit on the third location
        mem[11'h100] = 8'hFF; mem[11'h101] = 8'hFF; mem[11'h102] = 8'hEF; mem[11'h103] = 8'hFF;
        op_data.delete();
        run_op(PGM_BLANK, 11'h100, 4, 0, 1, 0, 0);

        // program+verify with second location stuck at 00
        op_data = '{8'h11, 8'h22};
        stuck_en = 1'b1; stuck_addr = 11'h201; stuck_val = 8'h00;
        run_op(PGM_PROG_VERIFY, 11'h200, 2, 0, 1, 0, 0);
        stuck_en = 1'b0;

        // abort in the middle of the program pulse
        prog_aq.delete(); done_hi = 0;
        feed_stall = 0;
        feed_q = '{8'h66, 8'h99};
        @(negedge clk);
        mode = PGM_PROG; base_addr = 11'h050; count = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!prog_ce && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_pulse", prog_ce, 1);
        @(negedge clk);
        abort = 1'b1; abort_seen = 1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_prog_ce", prog_ce, 0);
        chk("abort_vdd_25", vdd_25, 0);
        chk("abort_dq_oe", eprom_dq_oe, 0);
        chk("abort_rd_n", rd_n, 1);
        chk("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_hi, 0);
        chk("abort_err_kept", err, 0);
        feed_q.delete();

        // count = 0, then start while busy is ignored
        op_data.delete();
        run_op(PGM_PROG, 11'h010, 0, 0, 1, 0, 0);
        op_data = '{mem[11'h300], mem[11'h301]};
        run_op(PGM_VERIFY, 11'h300, 2, 0, 1, 0, 3);

        // reset asserted during SETUP
        feed_stall = 0;
        feed_q = '{8'h77};
        @(negedge clk);
        mode = PGM_PROG; base_addr = 11'h123; count = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!vdd_25 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_setup", vdd_25, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        rst_n = 1'b1;
        feed_q.delete();
        @(negedge clk);

        // FETCH stalls for 5 cycles with no byte offered
        op_data = '{8'h96};
        run_op(PGM_PROG, 11'h124, 1, 0, 0, 5, 0);

        // random operations
        for (int k = 0; k < 12; k++) begin
            rm = 2'($urandom_range(3));
            rb = AW'($urandom);
            rn = $urandom_range(1, 4);
            rs = ($urandom_range(1) == 1) ? 30 : 0;
            op_data.delete();
            for (int i = 0; i < rn; i++) begin
                ra = AW'(rb + i);
                if (rm == PGM_VERIFY && $urandom_range(1) == 1) op_data.push_back(mem[ra]);
                else op_data.push_back(8'($urandom));
            end
            stuck_en   = ($urandom_range(2) == 0);
            stuck_addr = AW'(rb + $urandom_range(rn - 1));
            stuck_val  = 8'($urandom);
            run_op(rm, rb, rn, rs, rs == 0, 0, 0);
            stuck_en = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
